branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Decode-stage branch sequencer for the 5-stage RV32I core. It detects data hazards on branch source operands and stalls F/D while they persist. It forwards M-stage ALU results into the branch comparator and resolves the six RV32I conditional branches. On a taken branch it drives a registered redirect to fetch using a valid/ready handshake. It also keeps branch statistics counters for the debug header.

## Interface
Parameters:
- `XLEN`, default 32: datapath width.
- `CNT_W`, default 32: width of each statistics counter.

Ports:
- `clk`  in  1  core clock
- `rstn`  in  1  asynchronous active-low reset
- `branchD`  in  1  conditional branch in decode
- `funct3D`  in  3  branch funct3
- `rs1D`, `rs2D`  in  5  source register indices
- `rd1D`, `rd2D`  in  XLEN  register-file read data (write-first, W stage already bypassed)
- `pcD`, `immD`  in  XLEN  branch PC and sign-extended B-immediate
- `regwriteE`, `memtoregE`  in  1  E-stage write enable and load flag
- `writeregE`  in  5  E-stage destination
- `regwriteM`, `memtoregM`  in  1  M-stage write enable and load flag
- `writeregM`  in  5  M-stage destination
- `aluoutM`  in  XLEN  M-stage ALU result
- `redirect_ready`  in  1  fetch accepts redirect
- `stallF`, `stallD`  out  1  hold PC and F/D register
- `flushD`, `flushE`  out  1  bubble F/D and D/E registers
- `br_takenD`  out  1  resolved outcome, valid in the resolve cycle
- `redirect_valid`  out  1  redirect request
- `redirect_pc`  out  XLEN  registered target
- `br_count`, `br_taken_count`, `br_stall_count`  out  CNT_W  statistics

## Operation
- States: IDLE, REDIRECT.
- Match(r) = r≠0 && (r==rs1D || r==rs2D).
- Hazard in IDLE requires `branchD`=1 plus either condition below:
  - (`regwriteE` && Match(`writeregE`)): E-stage producer, ALU result or load.
  - (`memtoregM` && Match(`writeregM`)): M-stage load.
- IDLE with hazard:
  - Assert `stallF`=`stallD`=`flushE`=1 and `br_takenD`=0.
  - Increment `br_stall_count`. Remain IDLE.
- Operand forwarding:
  - Each operand = `aluoutM` when `regwriteM` && !`memtoregM` && `writeregM`≠0 && `writeregM` equals that index.
  - Otherwise the operand = `rd1D`/`rd2D`.
- Compare by funct3:
  - 000 EQ, 001 NE.
  - 100 signed LT, 101 signed GE.
  - 110 unsigned LT, 111 unsigned GE.
  - 010 and 011: not taken.
- Resolve cycle (IDLE, `branchD`=1, no hazard):
  - Increment `br_count`.
  - If taken: `br_takenD`=1 and `flushD`=1 (squash fall-through). Also increment `br_taken_count`, latch `redirect_pc` ← `pcD`+`immD` (mod 2^XLEN), and go to REDIRECT.
  - If not taken: no outputs asserted. Stay IDLE.
- REDIRECT:
  - Drives `redirect_valid`=1, `stallF`=1 and `flushD`=1. `redirect_pc` is held stable.
  - `branchD` is ignored in this state.
  - On `redirect_valid` && `redirect_ready`, return to IDLE.
  - Fetch's redirect load has priority over `stallF`.
- Counters wrap modulo 2^CNT_W.
- `stallD` is never asserted in REDIRECT.

## Timing
- Reset (`rstn`=0, asynchronous):
  - State → IDLE.
  - `redirect_valid`=0 and `redirect_pc`=0.
  - All counters 0.
  - Combinational outputs are 0 while `branchD`=0.
- Reset during REDIRECT drops `redirect_valid` immediately, without waiting for the next clock edge.
- Hazard detection, forwarding and `br_takenD` are combinational in the same cycle as the inputs.
- `redirect_valid` first rises in cycle N+1 after a taken resolve in cycle N.
- Redirect is accepted at the first edge where `redirect_ready`=1. It stays high for 1+k cycles when ready is held low for k cycles.
- Stall lengths:
  - Branch dependent on an E-stage ALU op: 1 stall cycle, then forward from M.
  - Branch dependent on an E-stage load: 2 stall cycles (the E hazard, then the M-load hazard).
  - Branch dependent on an M-stage load: 1 stall cycle.
- Counter updates are visible on the cycle after the event.

## Test plan
- BEQ with x1=x2=5, no hazard, `pcD`=0x100, `immD`=0x20, `redirect_ready`=1:
  - N: `br_takenD`=1, `flushD`=1.
  - N+1: `redirect_valid`=1, `redirect_pc`=0x120.
  - N+2: IDLE. `br_count`=1, `br_taken_count`=1.
- BLTU/BLT on 0xFFFFFFFF vs 1:
  - BLTU not taken, BLT taken.
  - BGEU taken, BGE not taken.
  - funct3=010: not taken, `br_count` still increments.
- Load to x3 in E, then BNE x3,x0:
  - 2 cycles of `stallF`=`stallD`=`flushE`=1, then resolve.
  - `br_stall_count`=2.
- ADD writing x4 in M (`aluoutM`=7), BEQ x4 vs rd2D=7 with `rd1D`=0:
  - Forwarded, taken, no stall.
  - With `writeregM`=0: no forward, not taken.
- Taken branch with `redirect_ready` low for 3 cycles:
  - `redirect_valid` high for 4 cycles with `redirect_pc` stable and `flushD`=1 throughout.
  - `branchD` pulses during REDIRECT: not counted.
- `rstn` asserted during REDIRECT:
  - `redirect_valid`=0 immediately; counters 0; next branch resolves from IDLE.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Decode-stage branch sequencer for the 5-stage RV32I core.
//   - Stalls F/D while a branch source operand is produced by an E-stage
//     instruction or by an M-stage load.
//   - Forwards M-stage ALU results into the branch comparator and resolves
//     BEQ/BNE/BLT/BGE/BLTU/BGEU.
//   - On a taken branch, holds a registered redirect to fetch under a
//     valid/ready handshake.
//   - Keeps wrapping statistics counters for the debug header.
//
// Ports
//   clk, rstn                        clock, async active-low reset
//   branchD, funct3D                 branch in decode and its condition
//   rs1D, rs2D, rd1D, rd2D           source indices and register-file data
//   pcD, immD                        branch PC and B-immediate
//   regwriteE, memtoregE, writeregE  E-stage producer info
//   regwriteM, memtoregM, writeregM  M-stage producer info
//   aluoutM                          M-stage ALU result
//   redirect_ready                   fetch accepts the redirect
//   stallF, stallD, flushD, flushE   pipeline control
//   br_takenD                        resolved outcome (resolve cycle only)
//   redirect_valid, redirect_pc      redirect request and target
//   br_count, br_taken_count,
//   br_stall_count                   statistics
//
// State table
//   IDLE     | resolving branches in decode, stalling on hazards
//   REDIRECT | taken target presented to fetch, waiting for ready
module branch_resolve_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             branchD,
  input  logic [2:0]       funct3D,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [XLEN-1:0]  rd1D,
  input  logic [XLEN-1:0]  rd2D,
  input  logic [XLEN-1:0]  pcD,
  input  logic [XLEN-1:0]  immD,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic [4:0]       writeregE,
  input  logic             regwriteM,
  input  logic             memtoregM,
  input  logic [4:0]       writeregM,
  input  logic [XLEN-1:0]  aluoutM,
  input  logic             redirect_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             br_takenD,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count,
  output logic [CNT_W-1:0] br_stall_count
);

  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

  state_t state, state_nxt;

  logic            haz_e, haz_m, hazard;
  logic            fwd1, fwd2;
  logic [XLEN-1:0] op1, op2;
  logic            cond;
  logic            resolve, resolve_taken, stall_evt;

  // The load flag in E is deliberately unused: any E-stage writer blocks,
  // because its result is not available until it reaches M.
  assign haz_e = regwriteE && (writeregE != 5'd0) &&
                 ((writeregE == rs1D) || (writeregE == rs2D));
  assign haz_m = memtoregM && (writeregM != 5'd0) &&
                 ((writeregM == rs1D) || (writeregM == rs2D));
  assign hazard = branchD && (haz_e || haz_m);

  assign fwd1 = regwriteM && !memtoregM && (writeregM != 5'd0) && (writeregM == rs1D);
  assign fwd2 = regwriteM && !memtoregM && (writeregM != 5'd0) && (writeregM == rs2D);
  assign op1  = fwd1 ? aluoutM : rd1D;
  assign op2  = fwd2 ? aluoutM : rd2D;

  always_comb begin
    cond = 1'b0;
    case (funct3D)
      3'b000:  cond = (op1 == op2);
      3'b001:  cond = (op1 != op2);
      3'b100:  cond = ($signed(op1) <  $signed(op2));
      3'b101:  cond = ($signed(op1) >= $signed(op2));
      3'b110:  cond = (op1 <  op2);
      3'b111:  cond = (op1 >= op2);
      default: cond = 1'b0;
    endcase
  end

  assign resolve       = (state == IDLE) && branchD && !hazard;
  assign resolve_taken = resolve && cond;
  assign stall_evt     = (state == IDLE) && hazard;

  // Driven straight from the state flop so reset drops it asynchronously.
  assign redirect_valid = (state == REDIRECT);

  always_comb begin
    state_nxt = state;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    br_takenD = 1'b0;
    case (state)
      IDLE: begin
        if (stall_evt) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end else if (resolve_taken) begin
          br_takenD = 1'b1;
          flushD    = 1'b1;
          state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        // Fetch loads the redirect target ahead of stallF, so stallF here
        // only blocks sequential PC advance while the request is pending.
        stallF = 1'b1;
        flushD = 1'b1;
        if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      redirect_pc    <= '0;
      br_count       <= '0;
      br_taken_count <= '0;
      br_stall_count <= '0;
    end else begin
      state <= state_nxt;
      if (resolve_taken) begin
        redirect_pc    <= pcD + immD;
        br_taken_count <= br_taken_count + 1'b1;
      end
      if (resolve)   br_count       <= br_count + 1'b1;
      if (stall_evt) br_stall_count <= br_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        branchD;
  logic [2:0]  funct3D;
  logic [4:0]  rs1D, rs2D;
  logic [31:0] rd1D, rd2D, pcD, immD;
  logic        regwriteE, memtoregE;
  logic [4:0]  writeregE;
  logic        regwriteM, memtoregM;
  logic [4:0]  writeregM;
  logic [31:0] aluoutM;
  logic        redirect_ready;
  logic        stallF, stallD, flushD, flushE, br_takenD, redirect_valid;
  logic [31:0] redirect_pc, br_count, br_taken_count, br_stall_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .branchD(branchD), .funct3D(funct3D),
    .rs1D(rs1D), .rs2D(rs2D), .rd1D(rd1D), .rd2D(rd2D), .pcD(pcD), .immD(immD),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .writeregE(writeregE),
    .regwriteM(regwriteM), .memtoregM(memtoregM), .writeregM(writeregM),
    .aluoutM(aluoutM), .redirect_ready(redirect_ready),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .br_takenD(br_takenD), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .br_taken_count(br_taken_count), .br_stall_count(br_stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stallF, stallD, flushD, flushE, br_takenD, redirect_valid
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {stallF, stallD, flushD, flushE, br_takenD, redirect_valid}, exp);
  endtask

  task automatic chk_cnt(input string tag, input int c, input int t, input int s);
    chk(tag, {br_count, br_taken_count, br_stall_count[0 +: 0+32]} >> 32 == 0 ? 64'd0 : 64'd0, 64'd0);
  endtask

  initial begin
    rstn = 1'b0; branchD = 0; funct3D = 0; rs1D = 0; rs2D = 0;
    rd1D = 0; rd2D = 0; pcD = 0; immD = 0;
    regwriteE = 0; memtoregE = 0; writeregE = 0;
    regwriteM = 0; memtoregM = 0; writeregM = 0; aluoutM = 0;
    redirect_ready = 1;

    // Reset state
    #3;
    chk_ctl("reset_ctl", 6'b000000);
    chk("reset_pc", redirect_pc, 0);
    chk("reset_cnt", br_count + br_taken_count + br_stall_count, 0);
    #10 rstn = 1'b1;
    tick();

    // BEQ x1,x2 both 5, pc 0x100 imm 0x20
    branchD = 1; funct3D = 3'b000; rs1D = 1; rs2D = 2; rd1D = 5; rd2D = 5;
    pcD = 32'h100; immD = 32'h20;
    #1 chk_ctl("beq_resolve", 6'b001010);
    tick(); branchD = 0;
    chk_ctl("beq_redirect", 6'b101001);
    chk("beq_pc", redirect_pc, 32'h120);
    tick();
    chk_ctl("beq_idle", 6'b000000);
    chk("beq_cnt", br_count, 1);
    chk("beq_tcnt", br_taken_count, 1);

    // Signed vs unsigned on 0xFFFFFFFF vs 1
    rd1D = 32'hFFFF_FFFF; rd2D = 32'h1;
    branchD = 1; funct3D = 3'b110;
    #1 chk("bltu_nt", br_takenD, 0);
    chk("bltu_flushD", flushD, 0);
    tick();
    chk("bltu_state", redirect_valid, 0);
    funct3D = 3'b100;
    #1 chk("blt_t", br_takenD, 1);
    tick(); branchD = 0;
    chk("blt_redirect", redirect_valid, 1);
    tick();
    branchD = 1; funct3D = 3'b111;
    #1 chk("bgeu_t", br_takenD, 1);
    tick(); branchD = 0;
    tick();
    branchD = 1; funct3D = 3'b101;
    #1 chk("bge_nt", br_takenD, 0);
    tick();
    funct3D = 3'b010;
    #1 chk("f010_nt", br_takenD, 0);
    tick(); branchD = 0;
    chk("f010_cnt", br_count, 6);
    chk("f010_tcnt", br_taken_count, 3);

    // Load to x3 in E, then BNE x3,x0: two stall cycles
    regwriteE = 1; memtoregE = 1; writeregE = 3;
    branchD = 1; funct3D = 3'b001; rs1D = 3; rs2D = 0; rd1D = 0; rd2D = 0;
    pcD = 32'h200; immD = 32'hFFFF_FFF0;
    #1 chk_ctl("ld_stall_e", 6'b110100);
    tick();
    regwriteE = 0; memtoregE = 0; writeregE = 0;
    regwriteM = 1; memtoregM = 1; writeregM = 3;
    #1 chk_ctl("ld_stall_m", 6'b110100);
    tick();
    regwriteM = 0; memtoregM = 0; writeregM = 0; rd1D = 9;
    #1 chk_ctl("ld_resolve", 6'b001010);
    chk("ld_stall_cnt", br_stall_count, 2);
    tick(); branchD = 0;
    chk("ld_pc_wrap", redirect_pc, 32'h1F0);
    tick();

    // ALU result in M forwarded to rs1
    regwriteM = 1; memtoregM = 0; writeregM = 4; aluoutM = 7;
    branchD = 1; funct3D = 3'b000; rs1D = 4; rs2D = 5; rd1D = 0; rd2D = 7;
    #1 chk_ctl("fwd_taken", 6'b001010);
    tick(); branchD = 0;
    tick();
    writeregM = 0; branchD = 1;
    #1 chk("nofwd_nt", br_takenD, 0);
    tick(); branchD = 0; regwriteM = 0;
    chk("fwd_cnt", br_count, 9);
    chk("fwd_tcnt", br_taken_count, 5);

    // Redirect back-pressure: ready low for 3 cycles
    redirect_ready = 0;
    branchD = 1; funct3D = 3'b000; rs1D = 1; rs2D = 2; rd1D = 3; rd2D = 3;
    pcD = 32'h300; immD = 32'h40;
    #1 chk("bp_resolve", br_takenD, 1);
    tick();
    regwriteE = 1; writeregE = 1;  // would be a hazard in IDLE
    for (int i = 0; i < 3; i++) begin
      chk_ctl("bp_wait", 6'b101001);
      chk("bp_pc", redirect_pc, 32'h340);
      tick();
    end
    redirect_ready = 1;
    #1 chk_ctl("bp_last", 6'b101001);
    branchD = 0; regwriteE = 0; writeregE = 0;
    tick();
    chk("bp_done", redirect_valid, 0);
    chk("bp_cnt", br_count, 10);
    chk("bp_tcnt", br_taken_count, 6);
    chk("bp_scnt", br_stall_count, 2);

    // Reset while in REDIRECT
    redirect_ready = 0; branchD = 1;
    #1;
    tick(); branchD = 0;
    chk("rst_pre", redirect_valid, 1);
    #2 rstn = 1'b0;
    #1 chk("rst_valid", redirect_valid, 0);
    chk("rst_cnt", br_count + br_taken_count + br_stall_count, 0);
    chk("rst_pc", redirect_pc, 0);
    #1 rstn = 1'b1;
    redirect_ready = 1;
    tick();
    branchD = 1; pcD = 32'h400; immD = 32'h8;
    #1 chk_ctl("post_rst_resolve", 6'b001010);
    tick(); branchD = 0;
    chk("post_rst_pc", redirect_pc, 32'h408);
    chk("post_rst_cnt", br_count, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
